// File: rtl/spi_adis_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_adis_pkg
// Brief   : Shared types and constants for the ADIS-style SPI register slave.
// Revision: 1.0 - initial release
// ============================================================================
package spi_adis_pkg;

    // Frame-level state of the slave
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_END   = 2'd2
    } state_e;

    localparam int         FRAME_BITS = 16;
    localparam int         REG_WORDS  = 32;
    localparam logic [6:0] ADDR_LIMIT = 7'h40;

    // Bit counter saturates one past a legal frame so long frames stay "wrong"
    localparam logic [4:0] CNT_SAT    = 5'd17;

endpackage : spi_adis_pkg
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module  : spi_sync_edge
// Brief   : Multi-flop synchronizer with single-clk rise/fall pulses taken
//           from the synchronized level.
// Revision: 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   level;

    // Synchronizer chain plus one history flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Edge pulses compare the synchronized level with its previous value
    always_comb begin
        level  = sync_q[SYNC_STAGES-1];
        rise_o = level & ~prev_q;
        fall_o = ~level & prev_q;
    end

endmodule : spi_sync_edge
`default_nettype wire

// File: rtl/spi_adis_slave.sv
`default_nettype none
// ============================================================================
// Module  : spi_adis_slave
// Brief   : 16-bit SPI slave (CPOL=1, CPHA=1) fronting a 32 x 16-bit register
//           file. Reads return data in the following frame; writes commit one
//           byte at frame end. Host side has its own write port.
// Revision: 1.0 - initial release
// ============================================================================
module spi_adis_slave
    import spi_adis_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        rx,
    output logic        tx,
    input  logic        reg_wr_en,
    input  logic [4:0]  reg_addr,
    input  logic [15:0] reg_wdata,
    output logic        wr_evt,
    output logic [6:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        frame_done,
    output logic        frame_err
);

    state_e                 state_q, state_d;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] rx_sync_q;
    logic [4:0]             bit_cnt_q;
    logic [15:0]            rx_sh_q, tx_sh_q, resp_q, resp_d;
    logic                   first_fall_q;
    logic [15:0]            regs_q [REG_WORDS];
    logic                   wr_evt_q, done_q, err_q;
    logic [6:0]             wr_addr_q;
    logic [7:0]             wr_data_q;

    // Frame decode, valid only while in END
    logic                   frame_ok, is_wr, in_range, spi_commit, host_conflict;
    logic [6:0]             f_addr;
    logic [7:0]             f_data;
    logic [4:0]             f_word;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
        .clk(clk), .rst(rst), .d_i(sclk), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst(rst), .d_i(cs_n), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    // MOSI needs only a level synchronizer, matched in latency to sclk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_sync_q <= '0;
        else     rx_sync_q <= {rx_sync_q[SYNC_STAGES-2:0], rx};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: cs_n edges delimit the frame, END lasts one clk
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cs_fall) state_d = ST_SHIFT;
            ST_SHIFT: if (cs_rise) state_d = ST_END;
            ST_END:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output / decode logic derived from state and captured frame
    always_comb begin
        tx            = (state_q == ST_SHIFT) ? tx_sh_q[15] : 1'b0;
        frame_ok      = (bit_cnt_q == 5'(FRAME_BITS));
        is_wr         = rx_sh_q[15];
        f_addr        = rx_sh_q[14:8];
        f_data        = rx_sh_q[7:0];
        f_word        = f_addr[5:1];
        in_range      = (f_addr < ADDR_LIMIT);
        spi_commit    = (state_q == ST_END) && frame_ok && is_wr && in_range;
        host_conflict = spi_commit && (reg_addr == f_word);
        resp_d        = resp_q;
        if (state_q == ST_END) begin
            resp_d = (frame_ok && !is_wr && in_range) ? regs_q[f_word] : 16'h0000;
        end
    end

    // Shift datapath: sample MOSI on sclk rise, advance MISO on sclk fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q    <= '0;
            rx_sh_q      <= '0;
            tx_sh_q      <= '0;
            first_fall_q <= 1'b0;
        end else if (state_q == ST_IDLE && cs_fall) begin
            bit_cnt_q    <= '0;
            tx_sh_q      <= resp_q;
            first_fall_q <= 1'b1;
        end else if (state_q == ST_SHIFT) begin
            if (sclk_rise) begin
                rx_sh_q   <= {rx_sh_q[14:0], rx_sync_q[SYNC_STAGES-1]};
                bit_cnt_q <= (bit_cnt_q == CNT_SAT) ? bit_cnt_q : bit_cnt_q + 5'd1;
            end
            // Bit 15 is already on the line at frame start, so the first fall holds it
            if (sclk_fall) begin
                if (first_fall_q) first_fall_q <= 1'b0;
                else              tx_sh_q      <= {tx_sh_q[14:0], 1'b0};
            end
        end
    end

    // Response for the next frame and registered result pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_q    <= '0;
            wr_evt_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            resp_q   <= resp_d;
            wr_evt_q <= spi_commit;
            done_q   <= (state_q == ST_END) && frame_ok;
            err_q    <= (state_q == ST_END) && !frame_ok;
            if (spi_commit) begin
                wr_addr_q <= f_addr;
                wr_data_q <= f_data;
            end
        end
    end

    // Register file: SPI byte write wins; a colliding host write is discarded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_WORDS; i++) regs_q[i] <= '0;
        end else begin
            if (reg_wr_en && !host_conflict) regs_q[reg_addr] <= reg_wdata;
            if (spi_commit) begin
                if (f_addr[0]) regs_q[f_word][15:8] <= f_data;
                else           regs_q[f_word][7:0]  <= f_data;
            end
        end
    end

    assign wr_evt     = wr_evt_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule : spi_adis_slave
`default_nettype wire
